sym_fir_stream: RTL and testbench

//  Streaming symmetric (linear-phase) FIR: internal tap delay line, folded pre-add,

---
 rtl/fir_pkg.sv | 27 ++
 rtl/sym_fir_premul.sv | 48 ++++
 rtl/sym_fir_stream.sv | 208 ++++++++++++++++++++
 tb/tb_sym_fir_stream.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the symmetric streaming FIR: width helpers,
// default-width sample/coefficient/accumulator types and pipeline latency.
package fir_pkg;

  // Clock edges from sample acceptance to the registered output.
  localparam int LATENCY    = 32'sd3;

  localparam int DEF_NTAPS  = 32'sd37;
  localparam int DEF_DWIDTH = 32'sd14;
  localparam int DEF_CWIDTH = 32'sd11;

  // Number of unique coefficients of an odd-length symmetric filter.
  function automatic int nhalf(input int ntaps);
    return (ntaps + 32'sd1) / 32'sd2;
  endfunction

  // Full-precision sum width: folded sample (+1), coefficient, and growth of
  // summing nhalf products.
  function automatic int acc_width(input int dwidth, input int cwidth, input int ntaps);
    return dwidth + 32'sd1 + cwidth + $clog2(nhalf(ntaps));
  endfunction

  typedef logic signed [DEF_DWIDTH-1:0] sample_t;
  typedef logic signed [DEF_CWIDTH-1:0] coef_t;
  typedef logic signed [acc_width(DEF_DWIDTH, DEF_CWIDTH, DEF_NTAPS)-1:0] acc_t;

endpackage

// File: rtl/sym_fir_premul.sv
// One folded lane of the symmetric FIR: registers the pre-added tap pair,
// then registers its product with the lane coefficient. The centre lane
// (CENTER=1) carries a single sign-extended tap instead of a pair sum.
module sym_fir_premul
  import fir_pkg::*;
#(
  parameter int DWIDTH = 14,
  parameter int CWIDTH = 11,
  parameter bit CENTER = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DWIDTH-1:0]      tap_a,
  input  logic signed [DWIDTH-1:0]      tap_b,
  input  logic signed [CWIDTH-1:0]      coef,
  output logic signed [DWIDTH+CWIDTH:0] prod
);

  localparam int PW = DWIDTH + CWIDTH + 1;

  logic signed [DWIDTH:0] pre_s;
  logic signed [DWIDTH:0] pre_r;
  logic signed [PW-1:0]   prod_r;

  // Fold the symmetric tap pair; one extra bit keeps the sum exact.
  always_comb begin
    pre_s = '0;
    if (CENTER) begin
      pre_s = {tap_a[DWIDTH-1], tap_a};
    end else begin
      pre_s = {tap_a[DWIDTH-1], tap_a} + {tap_b[DWIDTH-1], tap_b};
    end
  end

  // Pre-add stage then multiply stage; both free-run, validity is tracked by the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r  <= '0;
      prod_r <= '0;
    end else begin
      pre_r  <= pre_s;
      prod_r <= PW'(pre_r) * PW'(coef);
    end
  end

  assign prod = prod_r;

endmodule

// File: rtl/sym_fir_stream.sv
// Streaming symmetric (linear-phase) FIR: tap delay line, folded pre-add,
// pipelined multiply and sum, runtime-loadable half-coefficient bank.
// Optional build macro FIR_OUT_SAT_EN: clamp the scaled output to the
// OWIDTH signed range and add a sat_flag output pulsing with dout_valid;
// without it the output wraps.
module sym_fir_stream
  import fir_pkg::*;
#(
  parameter int NTAPS     = 37,
  parameter int DWIDTH    = 14,
  parameter int CWIDTH    = 11,
  parameter int OWIDTH    = 26,
  parameter int OUT_SHIFT = 0
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            EN,
  input  logic                            din_valid,
  input  logic [DWIDTH-1:0]               din,
  input  logic                            flush,
  input  logic                            coef_we,
  input  logic [$clog2(nhalf(NTAPS))-1:0] coef_addr,
  input  logic [CWIDTH-1:0]               coef_wdata,
  output logic                            dout_valid,
  output logic [OWIDTH-1:0]               dout,
  output logic                            primed
`ifdef FIR_OUT_SAT_EN
  ,
  output logic                            sat_flag
`endif
);

  localparam int NHALF = nhalf(NTAPS);
  localparam int PW    = DWIDTH + CWIDTH + 1;
  localparam int CW    = $clog2(NTAPS + 1);
`ifdef FIR_OUT_SAT_EN
  localparam int SUM_W = acc_width(DWIDTH, CWIDTH, NTAPS);
`else
  // Wrapping output only depends on the low bits, and two's-complement
  // addition is exact modulo 2^SUM_W, so the upper sum bits are never built.
  localparam int SUM_W = OUT_SHIFT + OWIDTH;
`endif
  localparam logic [CW-1:0] FILL_FULL = CW'(NTAPS);
  localparam logic [CW-1:0] FILL_LAST = CW'(NTAPS - 1);

  logic signed [DWIDTH-1:0] tap_r  [NTAPS];
  logic signed [CWIDTH-1:0] coef_r [NHALF];
  logic signed [PW-1:0]     prod_s [NHALF];
  logic signed [SUM_W-1:0]  sum_s;
  logic [OWIDTH-1:0]        out_s;
  logic                     ovf_s;
  logic                     accept_s;
  logic                     tag_s;
  logic [CW-1:0]            fill_r;
  logic [CW-1:0]            fill_nxt_s;
  logic                     primed_r;
  logic                     v_tap_r;
  logic                     v_pre_r;
  logic                     v_mul_r;
  logic                     dout_valid_r;
  logic [OWIDTH-1:0]        dout_r;

  assign accept_s = EN & din_valid & ~flush;

  // Delay line: shift in accepted samples, cleared by flush.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 32'sd0; i < NTAPS; i++) tap_r[i] <= '0;
    end else if (flush) begin
      for (int i = 32'sd0; i < NTAPS; i++) tap_r[i] <= '0;
    end else if (accept_s) begin
      tap_r[0] <= din;
      for (int i = 32'sd1; i < NTAPS; i++) tap_r[i] <= tap_r[i-1];
    end
  end

  // Coefficient bank: writes outside the bank are ignored; flush leaves it alone.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 32'sd0; i < NHALF; i++) coef_r[i] <= '0;
    end else if (coef_we && (int'(coef_addr) < NHALF)) begin
      coef_r[coef_addr] <= coef_wdata;
    end
  end

  // Fill count of the delay line (saturating) and whether this sample yields an output.
  always_comb begin
    fill_nxt_s = fill_r;
    tag_s      = 1'b0;
    if (flush) begin
      fill_nxt_s = '0;
    end else if (accept_s) begin
      tag_s = (fill_r >= FILL_LAST);
      if (fill_r != FILL_FULL) begin
        fill_nxt_s = fill_r + CW'(1'b1);
      end else begin
        fill_nxt_s = fill_r;
      end
    end else begin
      fill_nxt_s = fill_r;
    end
  end

  // Fill counter and primed flag registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fill_r   <= '0;
      primed_r <= 1'b0;
    end else begin
      fill_r   <= fill_nxt_s;
      primed_r <= (fill_nxt_s == FILL_FULL);
    end
  end

  // Folded lanes: pair tap i with its mirror; the last lane is the centre tap.
  for (genvar g = 0; g < NHALF; g++) begin : g_lane
    sym_fir_premul #(
      .DWIDTH(DWIDTH),
      .CWIDTH(CWIDTH),
      .CENTER(g == (NHALF - 1))
    ) u_lane (
      .clk  (CLK),
      .rst  (RST),
      .tap_a(tap_r[g]),
      .tap_b(tap_r[NTAPS-1-g]),
      .coef (coef_r[g]),
      .prod (prod_s[g])
    );
  end

  // Sum the sign-extended lane products.
  always_comb begin
    sum_s = '0;
    for (int i = 32'sd0; i < NHALF; i++) begin
      sum_s = sum_s + SUM_W'(prod_s[i]);
    end
  end

`ifdef FIR_OUT_SAT_EN
  logic signed [SUM_W-1:0] shf_s;
  logic                    sat_r;

  // Scale, then clamp to the OWIDTH signed range when the upper bits disagree.
  always_comb begin
    shf_s = sum_s >>> OUT_SHIFT;
    ovf_s = ~((&shf_s[SUM_W-1:OWIDTH-1]) | ~(|shf_s[SUM_W-1:OWIDTH-1]));
    if (ovf_s) begin
      out_s = shf_s[SUM_W-1] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
    end else begin
      out_s = shf_s[OWIDTH-1:0];
    end
  end

  // Saturation flag pulses alongside the output it belongs to.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sat_r <= 1'b0;
    end else if (flush) begin
      sat_r <= 1'b0;
    end else begin
      sat_r <= v_mul_r & ovf_s;
    end
  end

  assign sat_flag = sat_r;
`else
  // Scale by truncation; overflow wraps.
  always_comb begin
    ovf_s = 1'b0;
    out_s = sum_s[OUT_SHIFT +: OWIDTH];
  end
`endif

  // Validity follows each tagged sample through pre-add, multiply and output;
  // flush drops everything in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_tap_r      <= 1'b0;
      v_pre_r      <= 1'b0;
      v_mul_r      <= 1'b0;
      dout_valid_r <= 1'b0;
    end else if (flush) begin
      v_tap_r      <= 1'b0;
      v_pre_r      <= 1'b0;
      v_mul_r      <= 1'b0;
      dout_valid_r <= 1'b0;
    end else begin
      v_tap_r      <= tag_s;
      v_pre_r      <= v_tap_r;
      v_mul_r      <= v_pre_r;
      dout_valid_r <= v_mul_r;
    end
  end

  // Output register: holds the last result until the next one emerges.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_r <= '0;
    end else if (v_mul_r && !flush) begin
      dout_r <= out_s;
    end
  end

  assign dout_valid = dout_valid_r;
  assign dout       = dout_r;
  assign primed     = primed_r;

endmodule

// File: tb/tb_sym_fir_stream.sv
// Self-checking bench for sym_fir_stream: table-driven steady-state vectors,
// hand-written corner sequences and randomized streaming against a direct
// convolution reference model.
`timescale 1ns/1ps
module tb_sym_fir_stream;
  import fir_pkg::*;

  localparam int NTAPS  = 37;
  localparam int NHALF  = 19;
  localparam int OMAX   = 33554431;
  localparam int OMIN   = -33554432;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN = 1'b0, din_valid = 1'b0, flush = 1'b0, coef_we = 1'b0;
  logic [13:0] din = '0;
  logic [4:0]  coef_addr = '0;
  logic [10:0] coef_wdata = '0;
  logic        dout_valid;
  logic [25:0] dout;
  logic        primed;
`ifdef FIR_OUT_SAT_EN
  logic        sat_flag;
`endif

  always #5 CLK = ~CLK;

  sym_fir_stream dut (
    .CLK(CLK), .RST(RST), .EN(EN), .din_valid(din_valid), .din(din),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .dout_valid(dout_valid), .dout(dout), .primed(primed)
`ifdef FIR_OUT_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Reference model state
  int coef_m [NHALF];
  int hist [$];
  int cnt;
  typedef struct { int due; int val; bit flag; } pend_t;
  pend_t pend [$];
  int got [$];

  typedef struct { int coef; int din; int exp_wrap; int exp_sat; } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (NTAPS) hist.push_back(0);
    cnt = 0;
    pend.delete();
  endtask

  // Direct-form convolution over the last NTAPS accepted samples.
  task automatic ref_out(output int v, output bit f);
    longint acc = 0;
    logic [25:0] t;
    for (int j = 0; j < NTAPS; j++)
      acc += longint'(hist[j]) * longint'(coef_m[(j < NHALF) ? j : NTAPS - 1 - j]);
    f = 1'b0;
`ifdef FIR_OUT_SAT_EN
    if (acc > OMAX) begin v = OMAX; f = 1'b1; end
    else if (acc < OMIN) begin v = OMIN; f = 1'b1; end
    else v = int'(acc);
`else
    t = acc[25:0];
    v = int'($signed(t));
`endif
  endtask

  task automatic model_edge();
    int v; bit f;
    if (RST) begin
      model_reset();
      for (int i = 0; i < NHALF; i++) coef_m[i] = 0;
      return;
    end
    if (coef_we && coef_addr < NHALF) coef_m[coef_addr] = int'($signed(coef_wdata));
    if (flush) begin
      model_reset();
    end else if (EN && din_valid) begin
      hist.push_front(int'($signed(din)));
      void'(hist.pop_back());
      if (cnt >= NTAPS - 1) begin
        ref_out(v, f);
        pend.push_back('{edge_n + LATENCY, v, f});
      end
      if (cnt < NTAPS) cnt++;
    end
  endtask

  task automatic check_cycle();
    bit ev;
    ev = (pend.size() > 0) && (pend[0].due == edge_n);
    chk("dout_valid", dout_valid, ev);
    if (ev && dout_valid) begin
      chk("dout", $signed(dout), pend[0].val);
`ifdef FIR_OUT_SAT_EN
      chk("sat_flag", sat_flag, pend[0].flag);
`endif
    end
    if (dout_valid) got.push_back(int'($signed(dout)));
    if (ev) void'(pend.pop_front());
    chk("primed", primed, cnt == NTAPS);
  endtask

  task automatic tick();
    @(posedge CLK);
    edge_n++;
    model_edge();
    #1;
    check_cycle();
  endtask

  task automatic cyc(input logic en, input logic v, input int d, input logic fl);
    EN = en; din_valid = v; din = d[13:0]; flush = fl;
    tick();
  endtask

  task automatic load_all(input int c);
    for (int i = 0; i < NHALF; i++) begin
      coef_we = 1'b1; coef_addr = 5'(i); coef_wdata = c[10:0];
      cyc(1'b0, 1'b0, 0, 1'b0);
    end
    coef_we = 1'b0;
  endtask

  task automatic check_impulse(input string name);
    chk({name, "_count"}, got.size() >= 38, 1);
    if (got.size() >= 38) begin
      for (int i = 0; i < 37; i++) chk(name, got[i], (i < NHALF) ? i + 1 : NTAPS - i);
      chk({name, "_tail"}, got[37], 0);
    end
  endtask

  initial begin
    vt[0] = '{1023,   8191, -25506779,  OMAX};
    vt[1] = '{1,       100,      3700,  3700};
    vt[2] = '{-1024,  8191,  25203712,  OMIN};
    vt[3] = '{3,        -5,      -555,  -555};
    vt[4] = '{-1024, -8192, -25165824,  OMAX};

    // Reset state
    RST = 1'b1;
    tick(); tick();
    chk("reset_dout", dout, 0);
    chk("reset_valid", dout_valid, 0);
    chk("reset_primed", primed, 0);
    RST = 1'b0;

    // 1: fill with zeros; primed and first output on the 37th sample
    got.delete();
    repeat (36) cyc(1'b1, 1'b1, 0, 1'b0);
    chk("t1_primed36", primed, 0);
    chk("t1_novalid36", got.size(), 0);
    cyc(1'b1, 1'b1, 0, 1'b0);
    chk("t1_primed37", primed, 1);
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
    chk("t1_valid37", got.size(), 1);
    if (got.size() > 0) chk("t1_dout37", got[0], 0);

    // 2: coef[i]=i+1, impulse response
    for (int i = 0; i < NHALF; i++) begin
      coef_we = 1'b1; coef_addr = 5'(i); coef_wdata = 11'(i + 1);
      cyc(1'b0, 1'b0, 0, 1'b0);
    end
    coef_we = 1'b0;
    got.delete();
    cyc(1'b1, 1'b1, 1, 1'b0);
    repeat (40) cyc(1'b1, 1'b1, 0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
    check_impulse("t2_impulse");

    // 5: EN gaps (1 on, 3 off) with the same impulse
    got.delete();
    cyc(1'b1, 1'b1, 1, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 777, 1'b0);
    repeat (38) begin
      cyc(1'b1, 1'b1, 0, 1'b0);
      repeat (3) cyc(1'b0, 1'b1, -5, 1'b0);
    end
    check_impulse("t5_gapped");

    // 3: table of steady-state vectors (overflow wraps or clamps)
    for (int k = 0; k < 5; k++) begin
      load_all(vt[k].coef);
      cyc(1'b0, 1'b0, 0, 1'b1);
      got.delete();
      repeat (37) cyc(1'b1, 1'b1, vt[k].din, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
      chk("t3_count", got.size(), 1);
`ifdef FIR_OUT_SAT_EN
      if (got.size() > 0) chk("t3_dout_sat", got[0], vt[k].exp_sat);
`else
      if (got.size() > 0) chk("t3_dout_wrap", got[0], vt[k].exp_wrap);
`endif
    end

    // 4: flush with a valid sample mid-stream
    repeat (40) cyc(1'b1, 1'b1, int'($urandom_range(0, 16383)), 1'b0);
    cyc(1'b1, 1'b1, 1234, 1'b1);
    chk("t4_primed_after_flush", primed, 0);
    got.delete();
    repeat (36) cyc(1'b1, 1'b1, int'($urandom_range(0, 16383)), 1'b0);
    chk("t4_novalid36", got.size(), 0);
    chk("t4_primed36", primed, 0);
    cyc(1'b1, 1'b1, int'($urandom_range(0, 16383)), 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
    chk("t4_valid37", got.size(), 1);

    // Randomized streaming against the reference model
    for (int i = 0; i < NHALF; i++) begin
      coef_we = 1'b1; coef_addr = 5'(i); coef_wdata = 11'($urandom_range(0, 2047));
      cyc(1'b0, 1'b0, 0, 1'b0);
    end
    coef_we = 1'b0;
    for (int n = 0; n < 900; n++) begin
      coef_we = (pend.size() == 0) && ($urandom_range(0, 9) == 0);
      coef_addr = 5'($urandom_range(0, 31));
      coef_wdata = 11'($urandom_range(0, 2047));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 16383)), $urandom_range(0, 59) == 0);
    end
    coef_we = 1'b0;

    // 6: reset during streaming clears outputs at once, coefficients read back as zero
    load_all(500);
    repeat (45) cyc(1'b1, 1'b1, int'($urandom_range(0, 16383)), 1'b0);
    EN = 1'b1; din_valid = 1'b1;
    RST = 1'b1;
    #1;
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_valid", dout_valid, 0);
    chk("t6_rst_primed", primed, 0);
    tick();
    RST = 1'b0;
    got.delete();
    repeat (45) cyc(1'b1, 1'b1, int'($urandom_range(1, 8000)), 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
    chk("t6_count", got.size(), 9);
    foreach (got[i]) chk("t6_zero_coef", got[i], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
